// File: rtl/io_scan_pkg.sv
// Shared definitions for the keypad scan controller: FSM states, io register
// map, parameter defaults and the row-decode helper.
package io_scan_pkg;

    localparam int SETTLE_DEF   = 4;
    localparam int DEBOUNCE_DEF = 3;

    localparam logic [2:0] REG_PA   = 3'b000;
    localparam logic [2:0] REG_DDRA = 3'b001;
    localparam logic [2:0] REG_PB   = 3'b010;
    localparam logic [2:0] REG_DDRB = 3'b011;

    typedef enum logic [2:0] {
        ST_CFG_DDRA,
        ST_CFG_DDRB,
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_READ,
        ST_CAPTURE,
        ST_EVAL
    } scan_state_t;

    // Returns {hit, index} of the lowest active-low row bit.
    function automatic logic [3:0] first_low(input logic [7:0] rows);
        first_low = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (!rows[i]) first_low = {1'b1, 3'(i)};
        end
    endfunction

endpackage

// File: rtl/io_scan_debounce.sv
// Match counter and report latch: turns per-scan candidates into single
// key_valid pulses once the same key has been seen on enough consecutive scans.
module io_scan_debounce
    import io_scan_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eval,
    input  logic       clear,
    input  logic       found,
    input  logic [5:0] cand,
    output logic       pulse
);

    localparam logic [2:0] DB_MAX = 3'(DEBOUNCE);

    logic [2:0] count;
    logic [2:0] count_nxt;
    logic [5:0] prev;
    logic       latched;

    // A zero count means the previous scan saw no key, so prev is meaningless.
    always_comb begin
        count_nxt = 3'd0;
        if (found) begin
            if (count != 3'd0 && cand == prev)
                count_nxt = (count == DB_MAX) ? count : count + 3'd1;
            else
                count_nxt = 3'd1;
        end
    end

    assign pulse = eval && found && (count_nxt == DB_MAX) && !latched;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count   <= 3'd0;
            prev    <= 6'd0;
            latched <= 1'b0;
        end else if (eval) begin
            count <= count_nxt;
            prev  <= cand;
            if (pulse)
                latched <= 1'b1;
            else if (!found)
                latched <= 1'b0;
        end
    end

endmodule

// File: rtl/io_scan_ctrl.sv
// 8x8 keypad scanner sharing the io block register port with a CPU; the CPU
// always wins the port and the scan FSM simply waits for it.
module io_scan_ctrl
    import io_scan_pkg::*;
#(
    parameter int SETTLE   = SETTLE_DEF,
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       tick,
    input  logic       cpu_req,
    input  logic       cpu_we_n,
    input  logic [2:0] cpu_a,
    input  logic [7:0] cpu_di,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    output logic       io_enable,
    output logic       io_we_n,
    output logic [2:0] io_a,
    output logic [7:0] io_di,
    input  logic [7:0] io_do,
    input  logic       io_oe,
    output logic       key_valid,
    output logic [5:0] key_code
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    scan_state_t state, state_nxt;
    logic [2:0]  col;
    logic [3:0]  settle_cnt;
    logic        cand_found;
    logic [5:0]  cand;
    logic        cpu_rd_pend;
    logic        scan_rd_pend;
    logic        scan_en_q;
    logic [7:0]  row_q;
    logic [7:0]  row_bits;
    logic [3:0]  low;
    logic        in_cfg, cfg_write, en_fall, advance, cap_go, eval_go, db_pulse;

    assign in_cfg    = (state == ST_CFG_DDRA) || (state == ST_CFG_DDRB);
    assign cfg_write = cpu_req && !cpu_we_n && (cpu_a == REG_DDRA || cpu_a == REG_DDRB);
    assign en_fall   = scan_en_q && !scan_en && !in_cfg;
    assign advance   = !cpu_req;

    // Row data arrives the cycle after READ; hold it in case CAPTURE is pre-empted.
    assign row_bits = scan_rd_pend ? (io_oe ? io_do : 8'hFF) : row_q;
    assign low      = first_low(row_bits);
    assign cap_go   = (state == ST_CAPTURE) && (state_nxt == ST_DRIVE || state_nxt == ST_EVAL);
    assign eval_go  = (state == ST_EVAL) && advance && !en_fall && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_CFG_DDRA;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cfg_write) begin
            state_nxt = ST_CFG_DDRA;
        end else if (en_fall) begin
            state_nxt = ST_IDLE;
        end else if (advance) begin
            unique case (state)
                ST_CFG_DDRA: state_nxt = ST_CFG_DDRB;
                ST_CFG_DDRB: state_nxt = ST_IDLE;
                ST_IDLE:     if (tick && scan_en) state_nxt = ST_DRIVE;
                ST_DRIVE:    state_nxt = ST_SETTLE;
                ST_SETTLE:   if (settle_cnt == SETTLE_LAST) state_nxt = ST_READ;
                ST_READ:     state_nxt = ST_CAPTURE;
                ST_CAPTURE:  state_nxt = (col == 3'd7) ? ST_EVAL : ST_DRIVE;
                ST_EVAL:     state_nxt = ST_IDLE;
                default:     state_nxt = ST_CFG_DDRA;
            endcase
        end
    end

    // NOTE: sequential state uses <= exclusively so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= 3'd0;
            settle_cnt   <= 4'd0;
            cand_found   <= 1'b0;
            cand         <= 6'd0;
            cpu_rd_pend  <= 1'b0;
            scan_rd_pend <= 1'b0;
            scan_en_q    <= 1'b0;
            row_q        <= 8'hFF;
        end else begin
            cpu_rd_pend  <= cpu_req && cpu_we_n;
            scan_rd_pend <= (state == ST_READ) && advance;
            scan_en_q    <= scan_en;
            if (scan_rd_pend) row_q <= row_bits;
            if (state == ST_IDLE && state_nxt == ST_DRIVE) begin
                col        <= 3'd0;
                cand_found <= 1'b0;
            end
            if (state == ST_DRIVE) settle_cnt <= 4'd0;
            if (state == ST_SETTLE && advance) settle_cnt <= settle_cnt + 4'd1;
            if (cap_go) begin
                col <= col + 3'd1;
                if (!cand_found && low[3]) begin
                    cand_found <= 1'b1;
                    cand       <= {col, low[2:0]};
                end
            end
        end
    end

    // NOTE: outputs are gated by rst because the reset state itself issues a write.
    always_comb begin
        cpu_gnt   = 1'b0;
        io_enable = 1'b0;
        io_we_n   = 1'b1;
        io_a      = REG_PA;
        io_di     = 8'h00;
        if (rst) begin
            io_enable = 1'b0;
        end else if (cpu_req) begin
            cpu_gnt   = 1'b1;
            io_enable = 1'b1;
            io_we_n   = cpu_we_n;
            io_a      = cpu_a;
            io_di     = cpu_di;
        end else begin
            unique case (state)
                ST_CFG_DDRA: begin io_enable = 1'b1; io_we_n = 1'b0; io_a = REG_DDRA; io_di = 8'hFF; end
                ST_CFG_DDRB: begin io_enable = 1'b1; io_we_n = 1'b0; io_a = REG_DDRB; io_di = 8'h00; end
                ST_DRIVE:    begin io_enable = 1'b1; io_we_n = 1'b0; io_a = REG_PA; io_di = ~(8'h01 << col); end
                ST_READ:     begin io_enable = 1'b1; io_we_n = 1'b1; io_a = REG_PB; end
                ST_EVAL:     begin io_enable = 1'b1; io_we_n = 1'b0; io_a = REG_PA; io_di = 8'hFF; end
                default:     io_enable = 1'b0;
            endcase
        end
    end

    assign cpu_rvalid = cpu_rd_pend && io_oe && !rst;
    assign cpu_rdata  = cpu_rvalid ? io_do : 8'h00;

    io_scan_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .eval  (eval_go),
        .clear (en_fall),
        .found (cand_found),
        .cand  (cand),
        .pulse (db_pulse)
    );

    assign key_valid = db_pulse && !rst;
    assign key_code  = key_valid ? cand : 6'd0;

endmodule

// File: tb/tb_io_scan_ctrl.sv
// Scoreboard bench for io_scan_ctrl with a behavioural io block and keypad matrix.
module tb_io_scan_ctrl;
    import io_scan_pkg::*;

    localparam int SETTLE   = 4;
    localparam int DEBOUNCE = 3;

    logic       clk = 1'b0, rst = 1'b1, scan_en = 1'b1, tick = 1'b0;
    logic       cpu_req = 1'b0, cpu_we_n = 1'b1;
    logic [2:0] cpu_a = 3'd0;
    logic [7:0] cpu_di = 8'd0;
    logic       cpu_gnt, cpu_rvalid, io_enable, io_we_n, key_valid;
    logic [7:0] cpu_rdata, io_di;
    logic [2:0] io_a;
    logic [5:0] key_code;
    logic [7:0] io_do = 8'd0;
    logic       io_oe = 1'b0;

    always #5 clk = ~clk;

    io_scan_ctrl #(.SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .tick(tick),
        .cpu_req(cpu_req), .cpu_we_n(cpu_we_n), .cpu_a(cpu_a), .cpu_di(cpu_di),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_enable(io_enable), .io_we_n(io_we_n), .io_a(io_a), .io_di(io_di),
        .io_do(io_do), .io_oe(io_oe), .key_valid(key_valid), .key_code(key_code)
    );

    int checks = 0, errors = 0, pulses = 0;
    logic [5:0]  exp_key[$];
    logic [7:0]  exp_rd[$];
    logic [10:0] exp_cfg[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // io block: PA/DDRA registers, PB reads the keypad rows; key index = {col,row}.
    logic [7:0]  pa_r = 8'hFF, ddra_r = 8'h00, m_data = 8'h00;
    logic [63:0] keys = '0;
    logic        m_rd = 1'b0;

    function automatic logic [7:0] pb_value();
        logic [7:0] v = 8'hFF;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                if (keys[c*8 + r] && ddra_r[c] && !pa_r[c]) v[r] = 1'b0;
        return v;
    endfunction

    always @(negedge clk) begin
        m_rd = 1'b0;
        if (io_enable) begin
            if (!io_we_n) begin
                if (io_a == REG_PA) pa_r = io_di;
                else if (io_a == REG_DDRA) ddra_r = io_di;
            end else begin
                m_rd   = 1'b1;
                m_data = (io_a == REG_PB) ? pb_value() : (io_a == REG_PA) ? pa_r : 8'h00;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        io_oe = m_rd;
        io_do = m_rd ? m_data : 8'h00;
    end

    // Monitor: pops the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                pulses++;
                check("key_expected", exp_key.size() != 0, 1);
                if (exp_key.size() != 0) check("key_code", key_code, exp_key.pop_front());
                check("key_in_eval", io_enable && !io_we_n && io_a == REG_PA && io_di == 8'hFF, 1);
            end
            if (cpu_rvalid) begin
                check("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) check("cpu_rdata", cpu_rdata, exp_rd.pop_front());
            end
            if (io_enable && !io_we_n && (io_a == REG_DDRA || io_a == REG_DDRB)) begin
                check("cfg_expected", exp_cfg.size() != 0, 1);
                if (exp_cfg.size() != 0) check("cfg_write", {io_a, io_di}, exp_cfg.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Waits for a scan-issued access; n = negedges waited, -1 on timeout.
    task automatic wait_acc(input string name, input logic [2:0] a, input logic we_n,
                            input logic [7:0] d, input bit use_d, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (io_enable && !cpu_gnt && io_a == a && io_we_n == we_n && (!use_d || io_di == d)) begin
                n = i;
                break;
            end
        end
        check({name, "_seen"}, n > 0, 1);
    endtask

    task automatic do_scan(input string tag);
        int n;
        pulse_tick();
        wait_acc({tag, "_drive"}, REG_PA, 1'b0, 8'hFE, 1'b1, n);
        check({tag, "_drive_lat"}, n, 1);
        wait_acc({tag, "_read"}, REG_PB, 1'b1, 8'h00, 1'b0, n);
        check({tag, "_settle"}, n, SETTLE + 1);
        wait_acc({tag, "_eval"}, REG_PA, 1'b0, 8'hFF, 1'b1, n);
        step();
    endtask

    task automatic idle_check(input string name, input int cycles);
        int busy = 0;
        repeat (cycles) begin
            @(negedge clk);
            busy += int'(io_enable);
        end
        check(name, busy, 0);
    endtask

    initial begin
        int n;
        // Reset: a CPU request must not leak through while rst is high.
        repeat (2) step();
        cpu_req = 1'b1; cpu_we_n = 1'b0; cpu_a = REG_DDRA; cpu_di = 8'hAA;
        @(negedge clk);
        check("reset_outputs", {io_enable, io_we_n, io_a, io_di, cpu_gnt, cpu_rvalid,
                                cpu_rdata, key_valid, key_code}, 32'd1 << 28);
        step();
        cpu_req = 1'b0; cpu_we_n = 1'b1;
        exp_cfg.push_back({REG_DDRA, 8'hFF});
        exp_cfg.push_back({REG_DDRB, 8'h00});
        rst = 1'b0;
        @(negedge clk);
        check("cfg_ddra", {io_enable, io_we_n, io_a, io_di}, {1'b1, 1'b0, REG_DDRA, 8'hFF});
        @(negedge clk);
        check("cfg_ddrb", {io_enable, io_we_n, io_a, io_di}, {1'b1, 1'b0, REG_DDRB, 8'h00});
        idle_check("idle_after_cfg", 6);
        step();

        // Single key col2/row5, three matching scans then one more.
        keys = '0; keys[6'h15] = 1'b1;
        do_scan("s1");
        do_scan("s2");
        check("no_pulse_before_db", pulses, 0);
        exp_key.push_back(6'h15);
        do_scan("s3");
        check("pulse_on_third", pulses, 1);
        do_scan("s4");
        check("no_repeat_pulse", pulses, 1);

        // Two keys: the lower column wins.
        keys = '0;
        do_scan("rel1");
        keys[6'h15] = 1'b1; keys[6'h0A] = 1'b1;
        do_scan("m1");
        do_scan("m2");
        check("multi_no_early", pulses, 1);
        exp_key.push_back(6'h0A);
        do_scan("m3");
        check("multi_pulse", pulses, 2);
        keys = '0;
        do_scan("rel2");

        // CPU read of PB during SETTLE delays READ by one cycle.
        keys[6'h03] = 1'b1;
        pulse_tick();
        wait_acc("c_drive", REG_PA, 1'b0, 8'hFE, 1'b1, n);
        step();
        cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_a = REG_PB;
        exp_rd.push_back(8'hF7);
        @(negedge clk);
        check("cpu_gnt_read", {cpu_gnt, io_enable, io_we_n, io_a}, {1'b1, 1'b1, 1'b1, REG_PB});
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_rvalid", cpu_rvalid, 1);
        wait_acc("c_read", REG_PB, 1'b1, 8'h00, 1'b0, n);
        check("read_delayed", n + 2, SETTLE + 2);
        wait_acc("c_eval", REG_PA, 1'b0, 8'hFF, 1'b1, n);
        step();

        // CPU write to DDRA mid-scan restarts config; debounce count (1) survives.
        pulse_tick();
        wait_acc("w_drive", REG_PA, 1'b0, 8'hFE, 1'b1, n);
        step();
        step();
        cpu_req = 1'b1; cpu_we_n = 1'b0; cpu_a = REG_DDRA; cpu_di = 8'h00;
        exp_cfg.push_back({REG_DDRA, 8'h00});
        exp_cfg.push_back({REG_DDRA, 8'hFF});
        exp_cfg.push_back({REG_DDRB, 8'h00});
        @(negedge clk);
        check("cpu_gnt_write", cpu_gnt, 1);
        step();
        cpu_req = 1'b0; cpu_we_n = 1'b1;
        @(negedge clk);
        check("restart_ddra", {io_enable, io_we_n, io_a, io_di}, {1'b1, 1'b0, REG_DDRA, 8'hFF});
        @(negedge clk);
        check("restart_ddrb", {io_enable, io_we_n, io_a, io_di}, {1'b1, 1'b0, REG_DDRB, 8'h00});
        idle_check("idle_after_restart", 5);
        step();
        do_scan("k1");
        check("kept_db_no_early", pulses, 2);
        exp_key.push_back(6'h03);
        do_scan("k2");
        check("kept_db_pulse", pulses, 3);
        keys = '0;
        do_scan("rel3");

        // scan_en dropped mid-scan clears debounce; three fresh scans needed.
        keys[6'h15] = 1'b1;
        do_scan("p1");
        do_scan("p2");
        pulse_tick();
        wait_acc("e_drive", REG_PA, 1'b0, 8'hFE, 1'b1, n);
        step();
        scan_en = 1'b0;
        step();
        scan_en = 1'b1;
        idle_check("idle_after_en_drop", 8);
        step();
        do_scan("f1");
        do_scan("f2");
        check("fresh_no_early", pulses, 3);
        exp_key.push_back(6'h15);
        do_scan("f3");
        check("fresh_pulse", pulses, 4);

        check("key_queue_empty", exp_key.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        check("cfg_queue_empty", exp_cfg.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish before 300000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/io_scan_ctrl.md
IO_SCAN_CTRL -- requirements
Module: io_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 4: idle cycles between column drive and row read (1..15).
REQ-002 Parameter DEBOUNCE, default 3: consecutive identical full scans before a key is reported (1..7).
REQ-003 Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- scan_en  in  1  enables keypad scanning.
- tick  in  1  one-cycle scan-start strobe.
- cpu_req  in  1  CPU requests an io register access this cycle.
- cpu_we_n  in  1  CPU access direction, 0 = write.
- cpu_a  in  3  CPU register address.
- cpu_di  in  8  CPU write data.
- cpu_gnt  out  1  CPU owns the io port this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  8  CPU read data.
- io_enable, io_we_n, io_a[2:0], io_di[7:0]  out  register-port command to the io block.
- io_do  in  8  io block read data.
- io_oe  in  1  io block read-data valid.
- key_valid  out  1  one-cycle new-key pulse.
- key_code  out  6  {column[2:0], row[2:0]} of the reported key.

Function
REQ-004 io block register map: PA=000, DDRA=001, PB=010, DDRB=011; 8x8 matrix, columns on PA, rows on PB, all active-low.
REQ-005 An access issued in cycle N is sampled by the io block at the falling edge of N; io_do/io_oe are captured at the rising edge ending cycle N+1.
REQ-006 CPU has absolute priority: when cpu_req=1, io_* mirror cpu_* with io_enable=1, cpu_gnt=1 combinationally, and the scan FSM holds state.
REQ-007 cpu_rvalid=1 and cpu_rdata=io_do one cycle after a granted CPU read when io_oe=1; otherwise cpu_rvalid=0.
REQ-008 When cpu_req=0 and the FSM is not in an access state, io_enable=0.
REQ-009 FSM states: CFG_DDRA (write FF to 001), CFG_DDRB (write 00 to 011), IDLE, DRIVE (write ~(1<<col) to 000), SETTLE, READ (read 010), CAPTURE, EVAL.
REQ-010 Each access state lasts exactly one cycle when not pre-empted by cpu_req.
REQ-011 CFG_DDRA -> CFG_DDRB -> IDLE; IDLE -> DRIVE with col=0 when tick=1 and scan_en=1.
REQ-012 DRIVE -> SETTLE; SETTLE counts SETTLE cycles -> READ -> CAPTURE.
REQ-013 CAPTURE: the first io_do bit equal to 0 (lowest row) from the lowest column yields the scan candidate; later zeros are ignored.
REQ-014 CAPTURE -> DRIVE with col+1 if col<7, else EVAL; col wraps 7->0.
REQ-015 EVAL: after the PA write of FF, the FSM returns to IDLE.
REQ-016 tick while not in IDLE is ignored.
REQ-017 Debounce: candidate equal to the previous scan's candidate increments a match count saturating at DEBOUNCE; a different candidate or no key resets it to 1 or 0 respectively.
REQ-018 key_valid pulses in EVAL when match count first reaches DEBOUNCE, with key_code = candidate.
REQ-019 No further pulse until a full scan with no key pressed.
REQ-020 A granted CPU write to DDRA or DDRB forces the FSM to CFG_DDRA on the next cycle, discarding the partial scan; debounce state is kept.
REQ-021 scan_en falling in any non-config state returns the FSM to IDLE next cycle and clears debounce state.

Reset
REQ-022 On rst: FSM = CFG_DDRA, col=0, match count=0, latch cleared, candidate cleared.
REQ-023 On rst: all outputs 0 except io_we_n=1.
REQ-024 rst mid-scan abandons the scan with no key_valid pulse.

Structure
REQ-025 Shared package io_scan_pkg holds the FSM state enum, register address constants, and SETTLE/DEBOUNCE defaults.
REQ-026 Debounce counter and report latch are one sub-module, io_scan_debounce.

Verification
REQ-027 Reset release, no CPU traffic -> writes FF@001 then 00@011 in consecutive cycles, then idle.
REQ-028 Key col 2/row 5 held, DEBOUNCE=3, three ticks -> single key_valid with key_code=0x15 on third EVAL; fourth scan gives no pulse.
REQ-029 Keys 0x15 and 0x0A both held -> key_code=0x0A reported.
REQ-030 cpu_req read of 010 during SETTLE -> cpu_gnt same cycle, cpu_rvalid next cycle, scan completes with READ delayed by exactly one cycle.
REQ-031 CPU writes 00 to DDRA mid-scan -> FSM restarts at CFG_DDRA and rewrites FF.
REQ-032 scan_en dropped mid-scan then reasserted -> no pulse until DEBOUNCE fresh matching scans.
